program_counter_high: RTL and testbench
=======================================

Name: program_counter_high

Overview:
- High byte of the 16-bit program counter.
- Consumes the PCLC carry produced by the PCL half and drives PCH onto the ADH and DB buses.
- Owns the relative-branch page-fixup sequence: when a taken branch's PCL add crosses a page, it spends one extra cycle adjusting PCH by +1 or -1.
- Sits beside the PCL register in the address datapath, under control of the instruction decoder/timing logic.

Parameters:
- WIDTH, 8, width of PCH and of the ADH/DB buses.
- RESET_VAL, 8'h00, PCH value after reset.

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- ADH_in  input  WIDTH  address bus high input.
- ADH_PCH  input  1  load PCH from ADH_in.
- PCH_PCH  input  1  recirculate (hold) PCH.
- PCH_DB  input  1  drive PCH onto DB_out.
- PCH_ADH  input  1  drive PCH onto ADH_out.
- increment  input  1  PC increment cycle; PCH increments when PCLC=1.
- PCLC  input  1  carry out from PCL.
- branch_start  input  1  one-cycle strobe: taken branch, PCL+offset computed this cycle.
- offset_neg  input  1  sign bit of branch offset, sampled with branch_start.
- branch_carry  input  1  carry out of the PCL+offset add, sampled with branch_start.
- DB_out  output  WIDTH  PCH when PCH_DB=1, else 0.
- ADH_out  output  WIDTH  PCH when PCH_ADH=1, else 0.
- fix_busy  output  1  high during the page-fixup cycle; decoder stalls the fetch.
- page_crossed  output  1  one-cycle pulse in the cycle after a branch_start that crosses a page.

Behaviour:
- Reset (async, nrst=0):
  - PCH=RESET_VAL, state=IDLE.
  - fix_busy=0, page_crossed=0.
  - DB_out and ADH_out follow the enables (0 while disabled).
- Output buses are combinational from the PCH register and the enables; both may be enabled at once.
- Base next value:
  - ADH_in if ADH_PCH=1; otherwise PCH (PCH_PCH or no source both hold).
  - ADH_PCH and PCH_PCH both high is a decoder error; ADH_PCH wins.
- Increment, IDLE only: if increment=1 and PCLC=1, next = base + 1, modulo 2^WIDTH (8'hFF -> 8'h00).
  - increment=1 with PCLC=0 leaves PCH unchanged.
- Page cross detect: cross = branch_carry XOR offset_neg, evaluated only when branch_start=1 in IDLE.
  - offset_neg=0, branch_carry=1 -> cross forward.
  - offset_neg=1, branch_carry=0 -> cross backward.
- FSM states: IDLE, FIX_UP, FIX_DOWN.
  - IDLE, branch_start=1, cross=1, offset_neg=0 -> FIX_UP; page_crossed=1 next cycle.
  - IDLE, branch_start=1, cross=1, offset_neg=1 -> FIX_DOWN; page_crossed=1 next cycle.
  - IDLE, branch_start=1, cross=0 -> stay IDLE; no extra cycle, page_crossed stays 0.
  - FIX_UP: fix_busy=1; at the clock edge PCH <= PCH+1 (wraps FF->00); -> IDLE.
  - FIX_DOWN: fix_busy=1; at the clock edge PCH <= PCH-1 (wraps 00->FF); -> IDLE.
- Latency: branch_start at cycle N -> fix_busy high in cycle N+1 -> corrected PCH visible in cycle N+2.
- Simultaneous events:
  - ADH_PCH=1 in FIX_UP/FIX_DOWN: load wins, fixup aborted, -> IDLE.
  - branch_start in FIX state: ignored.
  - increment&PCLC in FIX state: ignored (PCL is stalled by the decoder).
  - branch_start together with increment&PCLC in IDLE: the increment applies this cycle; cross is still evaluated.
- Reset mid-fixup: immediate return to IDLE, PCH=RESET_VAL, no pulse.

Decomposition:
- Shared package cpu_pkg:
  - typedef pch_state_t {IDLE, FIX_UP, FIX_DOWN}.
  - constant PC_RESET_HI = 8'h00.
  - WIDTH constant shared with the PCL block.
- No sub-module required.
- An optional inc/dec helper, pc_incdec (WIDTH-bit ±1 with wrap), is natural for sharing with the PCL block.

Test Plan:
- Reset: nrst=0 mid-operation with PCH=8'h3C -> PCH=00, fix_busy=0, ADH_out=00 (PCH_ADH=1).
- Load/drive: ADH_in=8'hA5, ADH_PCH=1 for one cycle, then PCH_DB=1, PCH_ADH=1 -> DB_out=ADH_out=A5; with both enables 0 -> both 00.
- Carry increment: PCH=FF, increment=1, PCLC=1 -> PCH=00. With PCLC=0 -> PCH stays FF.
- Forward cross: PCH=12, branch_start, offset_neg=0, branch_carry=1 -> fix_busy=1 and page_crossed=1 next cycle, then PCH=13, FSM IDLE.
- Backward cross with wrap: PCH=00, branch_start, offset_neg=1, branch_carry=0 -> one busy cycle, then PCH=FF. Same case with branch_carry=1 -> no busy cycle, PCH=00.
- Abort: enter FIX_UP from PCH=40, assert ADH_PCH with ADH_in=77 during the busy cycle -> PCH=77, IDLE, no +1 applied.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared by the PCL and PCH halves of the program counter.
package cpu_pkg;

    localparam int PC_WIDTH = 8;
    localparam logic [PC_WIDTH-1:0] PC_RESET_HI = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIX_UP   = 2'd1,
        FIX_DOWN = 2'd2
    } pch_state_t;

endpackage

// File: rtl/pc_incdec.sv
// WIDTH-bit +1 / -1 with natural wrap, shared by both program counter halves.
module pc_incdec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_val
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign o_val = i_dec ? (i_val - ONE) : (i_val + ONE);

endmodule

// File: rtl/program_counter_high.sv
// PCH register: carry increment from PCL, bus drivers and the branch page-fixup cycle.
//   state    | meaning
//   IDLE     | normal fetch; PCH loads, holds or takes the PCL carry
//   FIX_UP   | branch crossed forward; PCH+1 at the end of this cycle
//   FIX_DOWN | branch crossed backward; PCH-1 at the end of this cycle
module program_counter_high
    import cpu_pkg::*;
#(
    parameter int                WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = PC_RESET_HI
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] ADH_in,
    input  logic             ADH_PCH,
    input  logic             PCH_PCH,
    input  logic             PCH_DB,
    input  logic             PCH_ADH,
    input  logic             increment,
    input  logic             PCLC,
    input  logic             branch_start,
    input  logic             offset_neg,
    input  logic             branch_carry,
    output logic [WIDTH-1:0] DB_out,
    output logic [WIDTH-1:0] ADH_out,
    output logic             fix_busy,
    output logic             page_crossed
);

    pch_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pch, w_pch_nxt;
    logic             r_page_crossed, w_page_crossed_nxt;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_incdec;
    logic             w_cross;

    // PCH_PCH and "no source" both recirculate, so only the load needs decoding.
    assign w_base  = ADH_PCH ? ADH_in : r_pch;
    assign w_cross = branch_carry ^ offset_neg;

    // One adder serves the IDLE carry increment and both fixup directions.
    pc_incdec #(.WIDTH(WIDTH)) u_incdec (
        .i_val (w_base),
        .i_dec (r_state == FIX_DOWN),
        .o_val (w_incdec)
    );

    always_comb begin
        w_state_nxt        = IDLE;
        w_pch_nxt          = w_base;
        w_page_crossed_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (increment && PCLC)
                    w_pch_nxt = w_incdec;
                if (branch_start && w_cross) begin
                    w_state_nxt        = offset_neg ? FIX_DOWN : FIX_UP;
                    w_page_crossed_nxt = 1'b1;
                end
            end
            FIX_UP, FIX_DOWN: begin
                // A load during the fixup cycle supersedes the adjustment.
                if (!ADH_PCH)
                    w_pch_nxt = w_incdec;
            end
            default: begin
                w_state_nxt = IDLE;
                w_pch_nxt   = r_pch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= IDLE;
            r_pch          <= RESET_VAL;
            r_page_crossed <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pch          <= w_pch_nxt;
            r_page_crossed <= w_page_crossed_nxt;
        end
    end

    assign DB_out       = PCH_DB  ? r_pch : '0;
    assign ADH_out      = PCH_ADH ? r_pch : '0;
    assign fix_busy     = (r_state != IDLE);
    assign page_crossed = r_page_crossed;

endmodule

// File: tb/tb_program_counter_high.sv
// Scoreboard bench for program_counter_high: expected {DB,ADH,busy,pulse} queued per cycle.
module tb_program_counter_high;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] ADH_in;
    logic       ADH_PCH, PCH_PCH, PCH_DB, PCH_ADH;
    logic       increment, PCLC;
    logic       branch_start, offset_neg, branch_carry;
    logic [7:0] DB_out, ADH_out;
    logic       fix_busy, page_crossed;

    typedef struct {
        string      name;
        logic [17:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    program_counter_high #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .ADH_in       (ADH_in),
        .ADH_PCH      (ADH_PCH),
        .PCH_PCH      (PCH_PCH),
        .PCH_DB       (PCH_DB),
        .PCH_ADH      (PCH_ADH),
        .increment    (increment),
        .PCLC         (PCLC),
        .branch_start (branch_start),
        .offset_neg   (offset_neg),
        .branch_carry (branch_carry),
        .DB_out       (DB_out),
        .ADH_out      (ADH_out),
        .fix_busy     (fix_busy),
        .page_crossed (page_crossed)
    );

    function automatic logic [17:0] pack(input logic [7:0] pch, input logic busy, input logic pc);
        return {pch, pch, busy, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ADH_in       = 8'hC3;
        ADH_PCH      = 1'b0;
        PCH_PCH      = 1'b1;
        PCH_DB       = 1'b1;
        PCH_ADH      = 1'b1;
        increment    = 1'b0;
        PCLC         = 1'b0;
        branch_start = 1'b0;
        offset_neg   = 1'b0;
        branch_carry = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        idle_inputs();
        ADH_in  = v;
        ADH_PCH = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic branch(input logic neg, input logic carry);
        branch_start = 1'b1;
        offset_neg   = neg;
        branch_carry = carry;
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        #12;
        exp_q.push_back('{"reset_state", pack(8'h00, 1'b0, 1'b0)});
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        nrst = 1'b1;
        tick();
        load(8'h3C);
        exp_q.push_back('{"reset_async_mid", pack(8'h00, 1'b0, 1'b0)});
        #2 nrst = 1'b0;
        #1;
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_fixup();
        load(8'h3C);
        branch(1'b0, 1'b1);
        exp_q.push_back('{"rstfix_busy", pack(8'h3C, 1'b1, 1'b1)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        idle_inputs();
        exp_q.push_back('{"rstfix_async", pack(8'h00, 1'b0, 1'b0)});
        nrst = 1'b0;
        #1;
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        #2 nrst = 1'b1;
        exp_q.push_back('{"rstfix_after", pack(8'h00, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    task automatic test_load_drive();
        load(8'hA5);
        exp_q.push_back('{"load_drive", pack(8'hA5, 1'b0, 1'b0)});
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        PCH_DB = 1'b0; PCH_ADH = 1'b0;
        #1;
        checks++;
        if ({DB_out, ADH_out} !== 16'h0000) begin
            failures++; $display("FAIL drive_disabled actual=%h required=0000", {DB_out, ADH_out});
        end
        PCH_DB = 1'b1;
        #1;
        checks++;
        if ({DB_out, ADH_out} !== 16'hA500) begin
            failures++; $display("FAIL drive_db_only actual=%h required=a500", {DB_out, ADH_out});
        end
        idle_inputs();
        ADH_in = 8'h11;
        exp_q.push_back('{"hold_pch_pch", pack(8'hA5, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        ADH_in = 8'h5A; ADH_PCH = 1'b1; PCH_PCH = 1'b1;
        exp_q.push_back('{"load_wins_conflict", pack(8'h5A, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    task automatic test_increment();
        load(8'hFF);
        increment = 1'b1; PCLC = 1'b0;
        exp_q.push_back('{"inc_no_carry", pack(8'hFF, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        PCLC = 1'b1;
        exp_q.push_back('{"inc_wrap", pack(8'h00, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        increment = 1'b0;
        exp_q.push_back('{"carry_no_inc", pack(8'h00, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    task automatic test_fwd_cross(input logic [7:0] start, input logic [7:0] result);
        load(start);
        branch(1'b0, 1'b1);
        exp_q.push_back('{"fwd_busy", pack(start, 1'b1, 1'b1)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        idle_inputs();
        exp_q.push_back('{"fwd_done", pack(result, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    task automatic test_bwd_cross();
        load(8'h00);
        branch(1'b1, 1'b0);
        exp_q.push_back('{"bwd_busy", pack(8'h00, 1'b1, 1'b1)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        idle_inputs();
        exp_q.push_back('{"bwd_wrap", pack(8'hFF, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        load(8'h00);
        branch(1'b1, 1'b1);
        exp_q.push_back('{"bwd_no_cross", pack(8'h00, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        branch(1'b0, 1'b0);
        exp_q.push_back('{"fwd_no_cross", pack(8'h00, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    task automatic test_abort();
        load(8'h40);
        branch(1'b0, 1'b1);
        exp_q.push_back('{"abort_busy", pack(8'h40, 1'b1, 1'b1)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        idle_inputs();
        ADH_in = 8'h77; ADH_PCH = 1'b1;
        exp_q.push_back('{"abort_load", pack(8'h77, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        idle_inputs();
        exp_q.push_back('{"abort_settled", pack(8'h77, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    task automatic test_back_to_back();
        load(8'h12);
        branch(1'b0, 1'b1);
        increment = 1'b1; PCLC = 1'b1;
        exp_q.push_back('{"b2b_inc_and_branch", pack(8'h13, 1'b1, 1'b1)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        branch(1'b1, 1'b0);
        exp_q.push_back('{"b2b_fix_ignores", pack(8'h14, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
        idle_inputs();
        exp_q.push_back('{"b2b_idle", pack(8'h14, 1'b0, 1'b0)});
        tick();
        e = exp_q.pop_front(); checks++;
        if ({DB_out, ADH_out, fix_busy, page_crossed} !== e.v) begin
            failures++; $display("FAIL %s actual=%h required=%h", e.name, {DB_out, ADH_out, fix_busy, page_crossed}, e.v);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fixup();
        test_load_drive();
        test_increment();
        test_fwd_cross(8'h12, 8'h13);
        test_fwd_cross(8'hFF, 8'h00);
        test_bwd_cross();
        test_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
